vend_ctrl: RTL and testbench

Parametrised soda-vending controller and the successor to the fixed 20-unit vending block. It accumulates coin credit up to a cap and vends when the price is met, either automatically or on a buy request. It supports cancel/refund and pays change or refunds back as a sequence of physical coins, issued greedily one coin per cycle. It sits between the coin acceptor (one-cycle coin pulses) and the dispenser/coin-return mechanics.

---
 rtl/vend_ctrl.sv | 172 +++++++++++++++++
 tb/tb_vend_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_ctrl.sv
// vend_ctrl: coin-credit soda vending controller.
// Credits coins to a cap, vends at price, pays change/refunds greedily.
module vend_ctrl #(
  parameter int PRICE_U      = 4,
  parameter int MAX_CREDIT_U = 9,
  parameter int CREDIT_W     = 4,
  parameter int AUTO_VEND    = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                nickle_i,
  input  logic                dime_i,
  input  logic                quarter_i,
  input  logic                buy_i,
  input  logic                cancel_i,
  output logic                soda_o,
  output logic [CREDIT_W-1:0] change_o,
  output logic                ret_nickle_o,
  output logic                ret_dime_o,
  output logic                ret_quarter_o,
  output logic                coin_rej_o,
  output logic                busy_o,
  output logic [CREDIT_W-1:0] credit_o
);

  typedef enum logic [1:0] {
    COLLECT,
    VEND,
    CHANGE,
    REFUND
  } state_t;

  localparam logic [CREDIT_W-1:0] PRICE = CREDIT_W'(PRICE_U);
  localparam logic [CREDIT_W:0]   MAXC  = (CREDIT_W+1)'(MAX_CREDIT_U);
  localparam logic [CREDIT_W-1:0] U1    = CREDIT_W'(1);
  localparam logic [CREDIT_W-1:0] U2    = CREDIT_W'(2);
  localparam logic [CREDIT_W-1:0] U5    = CREDIT_W'(5);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] pend_q, pend_d;
  logic [CREDIT_W-1:0] change_q, change_d;
  logic                soda_q, soda_d;
  logic                rn_q, rn_d;
  logic                rd_q, rd_d;
  logic                rq_q, rq_d;
  logic                rej_q, rej_d;
  logic                busy_q, busy_d;

  logic                coin_any;
  logic                coin_one;
  logic [CREDIT_W:0]   coin_v;
  logic [CREDIT_W:0]   sum;
  logic                vend_go;

  // Coin decode and capped credit sum, one bit wider so it never wraps
  always_comb begin
    coin_any = nickle_i | dime_i | quarter_i;
    coin_one = 1'b0;
    coin_v   = '0;
    unique case ({nickle_i, dime_i, quarter_i})
      3'b100: begin
        coin_one = 1'b1;
        coin_v   = (CREDIT_W+1)'(1);
      end
      3'b010: begin
        coin_one = 1'b1;
        coin_v   = (CREDIT_W+1)'(2);
      end
      3'b001: begin
        coin_one = 1'b1;
        coin_v   = (CREDIT_W+1)'(5);
      end
      default: ;
    endcase
    sum     = {1'b0, credit_q} + coin_v;
    vend_go = (credit_q >= PRICE) && ((AUTO_VEND != 0) || buy_i);
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    pend_d   = pend_q;
    change_d = '0;
    soda_d   = 1'b0;
    rn_d     = 1'b0;
    rd_d     = 1'b0;
    rq_d     = 1'b0;
    rej_d    = 1'b0;
    unique case (state_q)
      COLLECT: begin
        if (cancel_i) begin
          rej_d = coin_any;
          if (credit_q != '0) begin
            pend_d   = credit_q;
            credit_d = '0;
            state_d  = REFUND;
          end
        end else if (vend_go) begin
          rej_d    = coin_any;
          soda_d   = 1'b1;
          change_d = credit_q - PRICE;
          pend_d   = credit_q - PRICE;
          credit_d = '0;
          state_d  = VEND;
        end else if (coin_one && (sum <= MAXC)) begin
          credit_d = sum[CREDIT_W-1:0];
        end else begin
          rej_d = coin_any;
        end
      end
      VEND: begin
        rej_d   = coin_any;
        state_d = (pend_q != '0) ? CHANGE : COLLECT;
      end
      CHANGE, REFUND: begin
        rej_d = coin_any;
        if (pend_q >= U5) begin
          rq_d   = 1'b1;
          pend_d = pend_q - U5;
        end else if (pend_q >= U2) begin
          rd_d   = 1'b1;
          pend_d = pend_q - U2;
        end else if (pend_q != '0) begin
          rn_d   = 1'b1;
          pend_d = pend_q - U1;
        end
        if (pend_d == '0) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
    busy_d = (state_d != COLLECT);
  end

  // State and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= COLLECT;
      credit_q <= '0;
      pend_q   <= '0;
      change_q <= '0;
      soda_q   <= 1'b0;
      rn_q     <= 1'b0;
      rd_q     <= 1'b0;
      rq_q     <= 1'b0;
      rej_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      pend_q   <= pend_d;
      change_q <= change_d;
      soda_q   <= soda_d;
      rn_q     <= rn_d;
      rd_q     <= rd_d;
      rq_q     <= rq_d;
      rej_q    <= rej_d;
      busy_q   <= busy_d;
    end
  end

  assign soda_o        = soda_q;
  assign change_o      = change_q;
  assign ret_nickle_o  = rn_q;
  assign ret_dime_o    = rd_q;
  assign ret_quarter_o = rq_q;
  assign coin_rej_o    = rej_q;
  assign busy_o        = busy_q;
  assign credit_o      = credit_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: scoreboard bench, auto-vend and buy-vend instances.
// Shared stimulus; per-instance behavioural model feeds expectations.
module tb_vend_ctrl;

  localparam int PRICE = 4;
  localparam int MAXC  = 9;

  typedef struct packed {
    logic       soda;
    logic [3:0] change;
    logic       rn;
    logic       rd;
    logic       rq;
    logic       rej;
    logic       busy;
    logic [3:0] credit;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic nickle_i = 1'b0;
  logic dime_i = 1'b0;
  logic quarter_i = 1'b0;
  logic buy_i = 1'b0;
  logic cancel_i = 1'b0;

  logic       a_soda, a_rn, a_rd, a_rq, a_rej, a_busy;
  logic [3:0] a_change, a_credit;
  logic       b_soda, b_rn, b_rd, b_rq, b_rej, b_busy;
  logic [3:0] b_change, b_credit;

  int n_chk = 0;
  int n_err = 0;

  exp_t qa[$];
  exp_t qb[$];

  int m_st[2];
  int m_cr[2];
  int m_pd[2];

  always #5 clk_i = ~clk_i;

  vend_ctrl #(
    .PRICE_U(PRICE), .MAX_CREDIT_U(MAXC),
    .CREDIT_W(4), .AUTO_VEND(1)
  ) dut_a (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .nickle_i(nickle_i), .dime_i(dime_i),
    .quarter_i(quarter_i), .buy_i(buy_i),
    .cancel_i(cancel_i),
    .soda_o(a_soda), .change_o(a_change),
    .ret_nickle_o(a_rn), .ret_dime_o(a_rd),
    .ret_quarter_o(a_rq), .coin_rej_o(a_rej),
    .busy_o(a_busy), .credit_o(a_credit)
  );

  vend_ctrl #(
    .PRICE_U(PRICE), .MAX_CREDIT_U(MAXC),
    .CREDIT_W(4), .AUTO_VEND(0)
  ) dut_b (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .nickle_i(nickle_i), .dime_i(dime_i),
    .quarter_i(quarter_i), .buy_i(buy_i),
    .cancel_i(cancel_i),
    .soda_o(b_soda), .change_o(b_change),
    .ret_nickle_o(b_rn), .ret_dime_o(b_rd),
    .ret_quarter_o(b_rq), .coin_rej_o(b_rej),
    .busy_o(b_busy), .credit_o(b_credit)
  );

  function automatic exp_t vec_a();
    return {a_soda, a_change, a_rn, a_rd, a_rq,
            a_rej, a_busy, a_credit};
  endfunction

  function automatic exp_t vec_b();
    return {b_soda, b_change, b_rn, b_rd, b_rq,
            b_rej, b_busy, b_credit};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // States: 0 collect, 1 vend, 2 change, 3 refund
  function automatic exp_t step(input int i, input bit av,
                                input bit n, input bit d,
                                input bit q, input bit b,
                                input bit c);
    exp_t e;
    int ncoin;
    int v;
    e = '0;
    ncoin = int'(n) + int'(d) + int'(q);
    v = int'(n) + 2 * int'(d) + 5 * int'(q);
    if (m_st[i] == 0) begin
      if (c) begin
        e.rej = (ncoin != 0);
        if (m_cr[i] > 0) begin
          m_pd[i] = m_cr[i];
          m_cr[i] = 0;
          m_st[i] = 3;
        end
      end else if (m_cr[i] >= PRICE && (av || b)) begin
        e.rej = (ncoin != 0);
        e.soda = 1'b1;
        e.change = 4'(m_cr[i] - PRICE);
        m_pd[i] = m_cr[i] - PRICE;
        m_cr[i] = 0;
        m_st[i] = 1;
      end else if (ncoin == 1 && m_cr[i] + v <= MAXC) begin
        m_cr[i] = m_cr[i] + v;
      end else begin
        e.rej = (ncoin != 0);
      end
    end else if (m_st[i] == 1) begin
      e.rej = (ncoin != 0);
      m_st[i] = (m_pd[i] > 0) ? 2 : 0;
    end else begin
      e.rej = (ncoin != 0);
      if (m_pd[i] >= 5) begin
        e.rq = 1'b1;
        m_pd[i] -= 5;
      end else if (m_pd[i] >= 2) begin
        e.rd = 1'b1;
        m_pd[i] -= 2;
      end else begin
        e.rn = 1'b1;
        m_pd[i] -= 1;
      end
      if (m_pd[i] == 0) m_st[i] = 0;
    end
    e.busy = (m_st[i] != 0);
    e.credit = 4'(m_cr[i]);
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0;
      m_cr[i] = 0;
      m_pd[i] = 0;
    end
    qa.delete();
    qb.delete();
  endtask

  task automatic cyc(input string tag,
                     input bit n, input bit d, input bit q,
                     input bit b, input bit c);
    exp_t ea;
    exp_t eb;
    nickle_i = n;
    dime_i = d;
    quarter_i = q;
    buy_i = b;
    cancel_i = c;
    qa.push_back(step(0, 1'b1, n, d, q, b, c));
    qb.push_back(step(1, 1'b0, n, d, q, b, c));
    @(posedge clk_i);
    #1;
    chk({tag, ".sb_a"}, qa.size(), 1);
    chk({tag, ".sb_b"}, qb.size(), 1);
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      chk({tag, ".a"}, vec_a(), ea);
    end
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      chk({tag, ".b"}, vec_b(), eb);
    end
  endtask

  task automatic idle(input string tag, input int k);
    for (int i = 0; i < k; i++) cyc(tag, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      nickle_i = 1'($urandom_range(0, 1));
      dime_i = 1'($urandom_range(0, 1));
      quarter_i = 1'($urandom_range(0, 1));
      buy_i = 1'($urandom_range(0, 1));
      cancel_i = 1'($urandom_range(0, 1));
      @(posedge clk_i);
      #1;
    end
    chk("rst.a", vec_a(), 0);
    chk("rst.b", vec_b(), 0);
    nickle_i = 0;
    dime_i = 0;
    quarter_i = 0;
    buy_i = 0;
    cancel_i = 0;
    rst_ni = 1'b1;
  endtask

  initial begin
    bit n, d, q;
    int r;
    do_reset();

    // Four nickels: auto vend with no change
    for (int i = 0; i < 4; i++) cyc("t2n", 1, 0, 0, 0, 0);
    chk("t2.cr", a_credit, 4);
    cyc("t2v", 0, 0, 0, 0, 0);
    chk("t2.soda", a_soda, 1);
    chk("t2.chg", a_change, 0);
    chk("t2.busy", a_busy, 1);
    idle("t2i", 3);
    chk("t2.idle", a_busy, 0);

    // Single quarter: one nickel of change
    do_reset();
    cyc("t3q", 0, 0, 1, 0, 0);
    chk("t3.cr", a_credit, 5);
    cyc("t3v", 0, 0, 0, 0, 0);
    chk("t3.chg", a_change, 1);
    cyc("t3c", 0, 0, 0, 0, 0);
    cyc("t3r", 0, 0, 0, 0, 0);
    chk("t3.rn", a_rn, 1);
    idle("t3i", 2);

    // Cancel with a coin on the same edge
    do_reset();
    cyc("t4d", 0, 1, 0, 0, 0);
    cyc("t4n", 1, 0, 0, 0, 0);
    cyc("t4c", 1, 0, 0, 0, 1);
    chk("t4.rej", a_rej, 1);
    cyc("t4r1", 0, 0, 0, 0, 0);
    chk("t4.rd", a_rd, 1);
    cyc("t4r2", 0, 0, 0, 0, 0);
    chk("t4.rn", a_rn, 1);
    chk("t4.cr", a_credit, 0);
    idle("t4i", 2);

    // Buy mode: cap rejection then change 3
    do_reset();
    cyc("t5q", 0, 0, 1, 0, 0);
    cyc("t5d", 0, 1, 0, 0, 0);
    chk("t5.cr7", b_credit, 7);
    cyc("t5q2", 0, 0, 1, 0, 0);
    chk("t5.rej", b_rej, 1);
    chk("t5.cr", b_credit, 7);
    cyc("t5b", 0, 0, 0, 1, 0);
    chk("t5.soda", b_soda, 1);
    chk("t5.chg", b_change, 3);
    cyc("t5v", 0, 0, 0, 0, 0);
    cyc("t5r1", 0, 0, 0, 0, 0);
    chk("t5.rd", b_rd, 1);
    cyc("t5r2", 0, 0, 0, 0, 0);
    chk("t5.rn", b_rn, 1);
    idle("t5i", 2);

    // Invalid coin, then a coin while busy
    do_reset();
    cyc("t6nd", 1, 1, 0, 0, 0);
    chk("t6.rej", a_rej, 1);
    chk("t6.cr", a_credit, 0);
    cyc("t6q", 0, 0, 1, 0, 0);
    cyc("t6v", 0, 0, 0, 0, 0);
    cyc("t6d", 0, 1, 0, 0, 0);
    chk("t6.brej", a_rej, 1);
    idle("t6i", 3);
    chk("t6.cr0", a_credit, 0);

    // Reset asserted mid-change drops coin pulses at once
    do_reset();
    for (int i = 0; i < 3; i++) cyc("t1n", 1, 0, 0, 0, 0);
    cyc("t1q", 0, 0, 1, 0, 0);
    chk("t1.cr8", a_credit, 8);
    cyc("t1v", 0, 0, 0, 0, 0);
    cyc("t1c", 0, 0, 0, 0, 0);
    cyc("t1r", 0, 0, 0, 0, 0);
    chk("t1.rd", a_rd, 1);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("t1.async_rd", a_rd, 0);
    chk("t1.async_busy", a_busy, 0);
    chk("t1.async_b", b_credit, 0);
    do_reset();
    idle("t1i", 3);
    chk("t1.noresume", a_rd, 0);

    // Random traffic against the model
    do_reset();
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 15);
      n = (r == 1) || (r == 4) || (r == 6);
      d = (r == 2) || (r == 4) || (r == 5);
      q = (r == 3) || (r == 5) || (r == 7);
      cyc("rnd", n, d, q,
          $urandom_range(0, 5) == 0,
          $urandom_range(0, 19) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
